// File: rtl/lvt_pkg.sv
// Shared constants, types and helpers for the LVT multiported RAM read side.
// Default geometry, address/select types and a per-port bus slicer.
package lvt_pkg;

  localparam int P_DEF           = 4;
  localparam int N_PE_BITS_DEF   = 2;
  localparam int INDEX_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF  = 32;

  typedef logic [INDEX_WIDTH_DEF-1:0] addr_t;
  typedef logic [N_PE_BITS_DEF-1:0]   sel_t;

  function automatic addr_t addr_slice(
    input logic [P_DEF*INDEX_WIDTH_DEF-1:0] bus,
    input int unsigned                      i
  );
    return bus[i*INDEX_WIDTH_DEF +: INDEX_WIDTH_DEF];
  endfunction

endpackage

// File: rtl/lvt_rd_port_pipe.sv
// One read port: issue, same-cycle write forwarding, bank select, 2-entry buffer.
// Ports: req_* in, lvt_/bank_ read ports out, wr_* snoop in, rsp_* out.
module lvt_rd_port_pipe
  import lvt_pkg::*;
#(
  parameter int p           = P_DEF,
  parameter int n_PE_bits   = N_PE_BITS_DEF,
  parameter int index_width = INDEX_WIDTH_DEF,
  parameter int data_width  = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [index_width-1:0]   req_addr,
  output logic                     lvt_ren,
  output logic [index_width-1:0]   lvt_raddr,
  input  logic [n_PE_bits-1:0]     lvt_sel,
  output logic                     bank_ren,
  output logic [index_width-1:0]   bank_raddr,
  input  logic [p*data_width-1:0]  bank_rdata,
  input  logic [p-1:0]             wr_en,
  input  logic [p*index_width-1:0] wr_addr,
  input  logic [p*data_width-1:0]  wr_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [data_width-1:0]    rsp_data
);

  logic                  accept;
  logic                  pop;
  logic                  b_valid;
  logic                  fwd_hit;
  logic                  fwd_hit_d;
  logic [data_width-1:0] fwd_data;
  logic [data_width-1:0] fwd_data_d;
  logic [data_width-1:0] sel_data;
  logic [data_width-1:0] push_data;
  logic [1:0]            occ;
  logic [2:0]            level;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [data_width-1:0] buf_mem [2];

  assign rsp_valid = occ != 2'd0;
  assign rsp_data  = buf_mem[rd_ptr];
  assign pop       = rsp_valid & rsp_ready;

  // Count the stage-B word as already occupying a slot.
  assign level     = {1'b0, occ} - {2'b0, pop} + {2'b0, b_valid};
  assign req_ready = level < 3'd2;
  assign accept    = req_valid & req_ready;

  assign lvt_ren    = accept;
  assign bank_ren   = accept;
  assign lvt_raddr  = req_addr;
  assign bank_raddr = req_addr;

  // Ascending scan: highest matching write port wins, as in the LVT.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    for (int j = 0; j < p; j++) begin
      if (wr_en[j] && wr_addr[j*index_width +: index_width] == req_addr) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = wr_data[j*data_width +: data_width];
      end
    end
  end

  // Out-of-range selects fall through to bank 0.
  always_comb begin
    sel_data = bank_rdata[0 +: data_width];
    for (int b = 1; b < p; b++) begin
      if (int'(lvt_sel) == b)
        sel_data = bank_rdata[b*data_width +: data_width];
    end
  end

  assign push_data = fwd_hit ? fwd_data : sel_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid    <= 1'b0;
      fwd_hit    <= 1'b0;
      fwd_data   <= '0;
      occ        <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      b_valid <= accept;
      if (accept) begin
        fwd_hit  <= fwd_hit_d;
        fwd_data <= fwd_data_d;
      end
      if (b_valid) begin
        buf_mem[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, b_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/lvt_mpram_read_port.sv
// Read-side controller of the LVT multiported RAM: p independent read pipes.
// Ports: rd_req_*/rd_rsp_* clients, lvt_*/bank_* array reads, wr_* snoop.
module lvt_mpram_read_port
  import lvt_pkg::*;
#(
  parameter int p           = P_DEF,
  parameter int n_PE_bits   = N_PE_BITS_DEF,
  parameter int index_width = INDEX_WIDTH_DEF,
  parameter int data_width  = DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p-1:0]               rd_req_valid,
  output logic [p-1:0]               rd_req_ready,
  input  logic [p*index_width-1:0]   rd_req_addr,
  output logic [p-1:0]               lvt_ren,
  output logic [p*index_width-1:0]   lvt_raddr,
  input  logic [p*n_PE_bits-1:0]     lvt_sel,
  output logic [p-1:0]               bank_ren,
  output logic [p*index_width-1:0]   bank_raddr,
  input  logic [p*p*data_width-1:0]  bank_rdata,
  input  logic [p-1:0]               wr_en,
  input  logic [p*index_width-1:0]   wr_addr,
  input  logic [p*data_width-1:0]    wr_data,
  output logic [p-1:0]               rd_rsp_valid,
  input  logic [p-1:0]               rd_rsp_ready,
  output logic [p*data_width-1:0]    rd_rsp_data
);

  for (genvar i = 0; i < p; i++) begin : g_port
    lvt_rd_port_pipe #(
      .p          (p),
      .n_PE_bits  (n_PE_bits),
      .index_width(index_width),
      .data_width (data_width)
    ) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .req_valid (rd_req_valid[i]),
      .req_ready (rd_req_ready[i]),
      .req_addr  (rd_req_addr[i*index_width +: index_width]),
      .lvt_ren   (lvt_ren[i]),
      .lvt_raddr (lvt_raddr[i*index_width +: index_width]),
      .lvt_sel   (lvt_sel[i*n_PE_bits +: n_PE_bits]),
      .bank_ren  (bank_ren[i]),
      .bank_raddr(bank_raddr[i*index_width +: index_width]),
      .bank_rdata(bank_rdata[i*p*data_width +: p*data_width]),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsp_valid (rd_rsp_valid[i]),
      .rsp_ready (rd_rsp_ready[i]),
      .rsp_data  (rd_rsp_data[i*data_width +: data_width])
    );
  end

endmodule

// File: doc/lvt_mpram_read_port.md
# lvt_mpram_read_port

Read-side controller for the LVT-based multiported RAM. For each of `p` read ports it issues the address to the live-value table and to all `p` bank RAMs, then uses the returned `lvt_sel` to pick the bank holding the live value. It forwards same-cycle writes and returns data over a per-port valid/ready response channel with a 2-entry output buffer. It sits between the read clients and the LVT/bank array; the LVT and the banks own the write path.

## Interface
- `p`, 4, number of read ports, write ports and banks.
- `n_PE_bits`, 2, width of a bank select; 2**n_PE_bits >= p.
- `index_width`, 8, address width.
- `data_width`, 32, word width.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rd_req_valid`  in  p  per-port request valid.
- `rd_req_ready`  out  p  per-port request ready.
- `rd_req_addr`  in  p*index_width  port i at `[i*index_width +: index_width]`.
- `lvt_ren`  out  p  LVT read enable per port.
- `lvt_raddr`  out  p*index_width  LVT read address per port.
- `lvt_sel`  in  p*n_PE_bits  LVT read data; 1-cycle synchronous latency; holds when not enabled.
- `bank_ren`  out  p  per port; enables that port's read of every bank.
- `bank_raddr`  out  p*index_width  same address to all banks for port i.
- `bank_rdata`  in  p*p*data_width  port i, bank b at `[(i*p+b)*data_width +: data_width]`; 1-cycle latency; read-old-data.
- `wr_en`  in  p  write-port enables, observed for forwarding.
- `wr_addr`  in  p*index_width  write addresses.
- `wr_data`  in  p*data_width  write data.
- `rd_rsp_valid`  out  p  response valid.
- `rd_rsp_ready`  in  p  response ready.
- `rd_rsp_data`  out  p*data_width  response data.

## Operation
- Ports are fully independent; there is no arbitration between read ports.
- Issue (stage A):
  - A request is accepted when `rd_req_valid[i] & rd_req_ready[i]`.
  - `lvt_ren[i] = bank_ren[i] = ` accept. Both read addresses are `rd_req_addr[i]`, combinational.
- Forward capture:
  - In the accept cycle, compare the address against every `wr_addr[j]` with `wr_en[j]`.
  - On a hit, register `fwd_hit=1` and `fwd_data = wr_data` of the highest matching j. This matches LVT last-writer-wins.
- Select (stage B, cycle after accept):
  - `sel = lvt_sel[i]`; data = `fwd_hit ? fwd_data : bank_rdata[i][sel]`.
  - `sel >= p` returns bank 0.
  - The result always enters the output buffer this cycle.
- Output buffer:
  - 2-entry FIFO per port; the head drives `rd_rsp_*`.
  - Pop on `rd_rsp_valid & rd_rsp_ready`.
- Flow control:
  - `rd_req_ready[i] = (occ - pop + b_valid) < 2`. The buffer never overflows.
  - Responses return in request order per port.
- Reset clears `b_valid`, `fwd_hit`, occupancy and pointers, and zeroes the buffer data. A reset mid-flight drops in-flight reads with no response.

## Timing
- Reset values:
  - `rd_rsp_valid=0`, `rd_rsp_data=0`.
  - `rd_req_ready` = all ones (combinational, empty).
  - `lvt_ren=bank_ren=0`.
- Latency: accept in cycle T, `rd_rsp_valid` high in T+2.
- Throughput: 1 read per port per cycle with `rd_rsp_ready` held high.
- Stall with `rd_rsp_ready` low from T+2:
  - The second request is accepted at T+1 and is buffered.
  - `rd_req_ready` is low from T+2 until the first pop.
- A write in the same cycle as the read accept returns the new data (forwarded).
- A write in cycle T+1 or later is not seen by a read accepted at T.
- A pop and a push in the same cycle with a full buffer is legal; occupancy is unchanged.

## Structure
- Package `lvt_pkg`:
  - default parameter constants;
  - `addr_t` and `sel_t` typedefs;
  - a function extracting a slice by port index.
- Sub-module `lvt_rd_port_pipe`: one port's issue, forward, select and 2-entry buffer. The top level instantiates it p times in a generate loop and slices the flat buses.

## Test plan
- Reset asserted mid-stream (p=4) → all `rd_rsp_valid=0`, `rd_rsp_data=0`, `rd_req_ready=4'hF` asynchronously; no stale response after release.
- Port 0 reads addr 0x10, `lvt_sel=2`, bank2 data 0xCAFE → `rd_rsp_data[0]=0xCAFE` exactly at T+2.
- Same-cycle write: ports 1 and 3 write addr 0x20 (0x11, 0x33) while port 2 reads 0x20 → response 0x33, ignoring bank data.
- Back-to-back: 8 reads on port 1 with `rd_rsp_ready=1` → 8 in-order responses on consecutive cycles, `rd_req_ready` constantly 1.
- Backpressure: `rd_rsp_ready=0` from T+2 → exactly 2 requests accepted, `rd_req_ready` low; release → both drain in order, then ready returns to 1.
- All 4 ports read distinct addresses in one cycle with different `lvt_sel` → each port's data comes from its own selected bank, with no cross-port interference.
